// File: rtl/ipv4_head_tx_stream_if.sv
// Request/stream bundle between the UDP header stage, the IPv4 header
// generator and the MAC framer. The generator uses the master view.
interface ipv4_head_tx_stream_if #(
   parameter int DATA_W = 16,
   parameter int LEN_W  = 16
);
   logic              start_v_i;
   logic [LEN_W-1:0]  data_len_i;
   logic              busy_o;
   logic              len_err_o;
   logic              head_v_o;
   logic              head_ready_i;
   logic [DATA_W-1:0] head_data_o;
   logic              head_last_o;
   logic [15:0]       id_o;

   modport master (
      input  start_v_i, data_len_i, head_ready_i,
      output busy_o, len_err_o, head_v_o, head_data_o, head_last_o, id_o
   );

   modport slave (
      output start_v_i, data_len_i, head_ready_i,
      input  busy_o, len_err_o, head_v_o, head_data_o, head_last_o, id_o
   );
endinterface

// File: rtl/ipv4_head_tx_stream.sv
// Streaming IPv4 header generator: latches a request, computes the RFC 791
// checksum in one cycle, then emits the 20-byte header as DATA_W-wide beats.
module ipv4_head_tx_stream #(
   parameter int          DATA_W   = 16,
   parameter int          LEN_W    = 16,
   parameter logic [31:0] SRC_ADDR = 32'hCEC8_7F80,
   parameter logic [31:0] DST_ADDR = 32'hCEC8_7F80,
   parameter logic [5:0]  DSCP     = 6'h2e,
   parameter logic [1:0]  ENC      = 2'b00,
   parameter logic [7:0]  TTL      = 8'd64,
   parameter logic [7:0]  PROTOCOL = 8'd17,
   parameter logic        DF       = 1'b1,
   parameter logic [15:0] ID_INIT  = 16'h0000
) (
   input logic                   clk,
   input logic                   reset,
   ipv4_head_tx_stream_if.master bus
);
   localparam int BEAT_N = 160 / DATA_W;
   localparam int CNT_W  = $clog2(BEAT_N);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEAT_N - 1);
   localparam logic [31:0] MAX_LEN = 32'd65515;

   // Every header word that does not depend on the request, summed once.
   localparam logic [19:0] STATIC_SUM =
      20'({4'h4, 4'h5, DSCP, ENC}) + 20'({1'b0, DF, 14'b0}) + 20'({TTL, PROTOCOL}) +
      20'(SRC_ADDR[31:16]) + 20'(SRC_ADDR[15:0]) +
      20'(DST_ADDR[31:16]) + 20'(DST_ADDR[15:0]);

   typedef enum logic [1:0] {IDLE, CSUM, SEND} state_t;

   state_t                        state_q, state_d;
   logic [15:0]                   tot_q, hid_q, csum_q, id_q;
   logic [CNT_W-1:0]              cnt_q;
   logic                          len_err_q;
   logic [LEN_W-1:0]              len_in;
   logic [31:0]                   len_ext;
   logic                          len_ok, fire, last_beat;
   logic [19:0]                   sum_raw, sum_f1;
   logic [15:0]                   sum_f2;
   logic [159:0]                  hdr;
   logic [BEAT_N-1:0][DATA_W-1:0] beats;

   assign len_in    = bus.data_len_i;
   assign len_ext   = 32'(len_in);
   assign len_ok    = (len_ext <= MAX_LEN);
   assign fire      = (state_q == SEND) && bus.head_ready_i;
   assign last_beat = (cnt_q == LAST_CNT);

   // Two folds are enough: after the first the carry is at most one bit.
   assign sum_raw = STATIC_SUM + 20'(tot_q) + 20'(hid_q);
   assign sum_f1  = 20'(sum_raw[15:0]) + 20'(sum_raw[19:16]);
   assign sum_f2  = sum_f1[15:0] + 16'(sum_f1[19:16]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start_v_i && len_ok) state_d = CSUM;
         CSUM:    state_d = SEND;
         SEND:    if (fire && last_beat) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tot_q     <= '0;
         hid_q     <= '0;
         csum_q    <= '0;
         cnt_q     <= '0;
         id_q      <= ID_INIT;
         len_err_q <= 1'b0;
      end else begin
         len_err_q <= (state_q == IDLE) && bus.start_v_i && !len_ok;
         if (state_q == IDLE && bus.start_v_i && len_ok) begin
            tot_q <= 16'(len_ext + 32'd20);
            hid_q <= id_q;
         end
         if (state_q == CSUM) begin
            csum_q <= ~sum_f2;
            cnt_q  <= '0;
         end
         if (fire) begin
            cnt_q <= cnt_q + 1'b1;
            if (last_beat) id_q <= id_q + 16'd1;
         end
      end
   end

   // Network byte 0 sits in the least significant byte so beat k is a plain slice.
   assign hdr = {DST_ADDR[7:0], DST_ADDR[15:8], DST_ADDR[23:16], DST_ADDR[31:24],
                 SRC_ADDR[7:0], SRC_ADDR[15:8], SRC_ADDR[23:16], SRC_ADDR[31:24],
                 csum_q[7:0], csum_q[15:8], PROTOCOL, TTL,
                 8'h00, {1'b0, DF, 6'b0}, hid_q[7:0], hid_q[15:8],
                 tot_q[7:0], tot_q[15:8], {DSCP, ENC}, 8'h45};
   assign beats = hdr;

   assign bus.busy_o      = (state_q != IDLE);
   assign bus.head_v_o    = (state_q == SEND);
   assign bus.head_last_o = (state_q == SEND) && last_beat;
   assign bus.head_data_o = (state_q == SEND) ? beats[cnt_q] : '0;
   assign bus.len_err_o   = len_err_q;
   assign bus.id_o        = id_q;
endmodule

// File: tb/tb_ipv4_head_tx_stream.sv
// Directed bench: reference checksum header at 8/16/32-bit beats, ID increment
// and wrap, backpressure, length boundary, busy start and mid-send reset.
module tb_ipv4_head_tx_stream;
   typedef logic [7:0] hdr_t [20];
   typedef logic [7:0] bq_t [$];

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ipv4_head_tx_stream_if #(.DATA_W(8),  .LEN_W(16)) ia ();
   ipv4_head_tx_stream_if #(.DATA_W(32), .LEN_W(16)) ib ();
   ipv4_head_tx_stream_if #(.DATA_W(16), .LEN_W(16)) ic ();

   ipv4_head_tx_stream #(.DATA_W(8), .LEN_W(16), .SRC_ADDR(32'hC0A80001), .DST_ADDR(32'hC0A800C7),
      .DSCP(6'h00), .ENC(2'b00), .TTL(8'd64), .PROTOCOL(8'd17), .DF(1'b1), .ID_INIT(16'h0000))
      u_a (.clk(clk), .reset(reset), .bus(ia));
   ipv4_head_tx_stream #(.DATA_W(32), .LEN_W(16), .SRC_ADDR(32'hC0A80001), .DST_ADDR(32'hC0A800C7),
      .DSCP(6'h00), .ENC(2'b00), .TTL(8'd64), .PROTOCOL(8'd17), .DF(1'b1), .ID_INIT(16'h0000))
      u_b (.clk(clk), .reset(reset), .bus(ib));
   ipv4_head_tx_stream #(.DATA_W(16), .LEN_W(16), .SRC_ADDR(32'hC0A80001), .DST_ADDR(32'hC0A800C7),
      .DSCP(6'h00), .ENC(2'b00), .TTL(8'd64), .PROTOCOL(8'd17), .DF(1'b1), .ID_INIT(16'hFFFF))
      u_c (.clk(clk), .reset(reset), .bus(ic));

   hdr_t ref_h = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                   8'hB8, 8'h61, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};
   logic [31:0] b_exp [5] = '{32'h73000045, 32'h00400000, 32'h61B81140, 32'h0100A8C0, 32'hC700A8C0};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Accepted-beat monitors, sampled on the falling edge.
   bq_t  qa, qc;
   logic qa_last [$];
   int   qa_cyc [$];
   logic [31:0] qb [$];
   logic b_stall = 1'b0;
   logic [31:0] b_prev = '0;

   always @(negedge clk) begin
      if (ia.head_v_o && ia.head_ready_i) begin
         qa.push_back(ia.head_data_o);
         qa_last.push_back(ia.head_last_o);
         qa_cyc.push_back(cyc);
      end
      if (ic.head_v_o && ic.head_ready_i) begin
         qc.push_back(ic.head_data_o[7:0]);
         qc.push_back(ic.head_data_o[15:8]);
      end
      if (b_stall) begin
         chk("b_hold_v", 32'(ib.head_v_o), 32'd1);
         chk("b_hold_d", ib.head_data_o, b_prev);
      end
      b_stall = ib.head_v_o && !ib.head_ready_i;
      b_prev  = ib.head_data_o;
      if (ib.head_v_o && ib.head_ready_i) qb.push_back(ib.head_data_o);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic busy_of(input int sel);
      case (sel)
         0:       return ia.busy_o;
         1:       return ib.busy_o;
         default: return ic.busy_o;
      endcase
   endfunction

   task automatic start_hdr(input int sel, input logic [15:0] len);
      case (sel)
         0:       begin ia.start_v_i = 1'b1; ia.data_len_i = len; end
         1:       begin ib.start_v_i = 1'b1; ib.data_len_i = len; end
         default: begin ic.start_v_i = 1'b1; ic.data_len_i = len; end
      endcase
      tick();
      ia.start_v_i = 1'b0;
      ib.start_v_i = 1'b0;
      ic.start_v_i = 1'b0;
   endtask

   task automatic wait_idle(input int sel, output int n);
      n = 1;
      while (busy_of(sel) && n < 200) begin
         tick();
         n++;
      end
      chk("idle_reached", 32'(busy_of(sel)), 32'd0);
   endtask

   task automatic cmp_hdr(input string tag, input bq_t got, input hdr_t exp);
      chk({tag, "_len"}, got.size(), 32'd20);
      for (int i = 0; i < 20; i++)
         if (i < got.size()) chk($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(exp[i]));
   endtask

   function automatic logic [15:0] ocsum(input bq_t q);
      logic [31:0] s;
      s = '0;
      if (q.size() < 20) return 16'h0;
      for (int i = 0; i < 10; i++) s += {16'h0, q[2*i], q[2*i+1]};
      s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
      s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
      return s[15:0];
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int   n, c0, last_c, nl;
      hdr_t exp;
      ia.start_v_i = 1'b0; ia.data_len_i = '0; ia.head_ready_i = 1'b0;
      ib.start_v_i = 1'b0; ib.data_len_i = '0; ib.head_ready_i = 1'b0;
      ic.start_v_i = 1'b0; ic.data_len_i = '0; ic.head_ready_i = 1'b0;
      tick();
      tick();
      chk("rst_busy",  32'(ia.busy_o),      32'd0);
      chk("rst_v",     32'(ia.head_v_o),    32'd0);
      chk("rst_last",  32'(ia.head_last_o), 32'd0);
      chk("rst_err",   32'(ia.len_err_o),   32'd0);
      chk("rst_data",  32'(ia.head_data_o), 32'd0);
      chk("rst_data_b", ib.head_data_o,     32'd0);
      chk("rst_id_a",  32'(ia.id_o),        32'h0000);
      chk("rst_id_c",  32'(ic.id_o),        32'hFFFF);
      reset = 1'b0;
      tick();
      ia.head_ready_i = 1'b1;
      ic.head_ready_i = 1'b1;

      // reference header, ready held high
      start_hdr(0, 16'd95);
      c0 = cyc;
      chk("a_busy_t1", 32'(ia.busy_o),   32'd1);
      chk("a_v_t1",    32'(ia.head_v_o), 32'd0);
      wait_idle(0, n);
      chk("a_idle_lat", n, 32'd22);
      cmp_hdr("ref", qa, ref_h);
      nl = 0;
      foreach (qa_last[i]) nl += int'(qa_last[i]);
      chk("a_last_cnt", nl, 32'd1);
      if (qa.size() == 20) begin
         chk("a_last_pos",  32'(qa_last[19]), 32'd1);
         chk("a_first_cyc", qa_cyc[0],  c0 + 1);
         chk("a_last_cyc",  qa_cyc[19], c0 + 20);
      end
      chk("a_id1", 32'(ia.id_o), 32'd1);

      // back-to-back start in the first idle cycle
      last_c = (qa_cyc.size() > 0) ? qa_cyc[qa_cyc.size()-1] : 0;
      qa.delete(); qa_last.delete(); qa_cyc.delete();
      start_hdr(0, 16'd95);
      wait_idle(0, n);
      exp = ref_h; exp[5] = 8'h01; exp[10] = 8'hB8; exp[11] = 8'h60;
      cmp_hdr("id1", qa, exp);
      if (qa_cyc.size() > 0) chk("b2b_gap", qa_cyc[0] - last_c, 32'd3);
      chk("a_id2", 32'(ia.id_o), 32'd2);

      // start while sending is ignored
      qa.delete(); qa_last.delete(); qa_cyc.delete();
      start_hdr(0, 16'd95);
      tick();
      tick();
      ia.start_v_i = 1'b1; ia.data_len_i = 16'd10;
      tick();
      tick();
      ia.start_v_i = 1'b0;
      wait_idle(0, n);
      for (int i = 0; i < 5; i++) tick();
      chk("busy_start_idle", 32'(ia.busy_o), 32'd0);
      exp = ref_h; exp[5] = 8'h02; exp[10] = 8'hB8; exp[11] = 8'h5F;
      cmp_hdr("busy_start", qa, exp);
      chk("a_id3", 32'(ia.id_o), 32'd3);

      // length boundary
      qa.delete(); qa_last.delete(); qa_cyc.delete();
      start_hdr(0, 16'd65516);
      chk("len_err_pulse", 32'(ia.len_err_o), 32'd1);
      chk("len_err_busy",  32'(ia.busy_o),    32'd0);
      tick();
      chk("len_err_clr",   32'(ia.len_err_o), 32'd0);
      chk("len_err_busy2", 32'(ia.busy_o),    32'd0);
      chk("len_err_id",    32'(ia.id_o),      32'd3);
      chk("len_err_nobeat", qa.size(),        32'd0);
      start_hdr(0, 16'd65515);
      wait_idle(0, n);
      exp = ref_h; exp[2] = 8'hFF; exp[3] = 8'hFF; exp[5] = 8'h03; exp[10] = 8'hB8; exp[11] = 8'hD1;
      cmp_hdr("len_max", qa, exp);
      chk("a_id4", 32'(ia.id_o), 32'd4);

      // reset during beat 3, then a fresh header
      qa.delete(); qa_last.delete(); qa_cyc.delete();
      start_hdr(0, 16'd95);
      for (int i = 0; i < 4; i++) tick();
      chk("beat3_data", 32'(ia.head_data_o), 32'h73);
      reset = 1'b1;
      #1;
      chk("mid_rst_v",    32'(ia.head_v_o),    32'd0);
      chk("mid_rst_busy", 32'(ia.busy_o),      32'd0);
      chk("mid_rst_data", 32'(ia.head_data_o), 32'd0);
      chk("mid_rst_id",   32'(ia.id_o),        32'd0);
      tick();
      reset = 1'b0;
      tick();
      qa.delete(); qa_last.delete(); qa_cyc.delete();
      start_hdr(0, 16'd95);
      wait_idle(0, n);
      cmp_hdr("after_rst", qa, ref_h);
      chk("a_id_after_rst", 32'(ia.id_o), 32'd1);

      // 32-bit beats with ready toggling every cycle
      start_hdr(1, 16'd95);
      n = 0;
      while (ib.busy_o && n < 200) begin
         ib.head_ready_i = ~ib.head_ready_i;
         tick();
         n++;
      end
      chk("b_idle", 32'(ib.busy_o), 32'd0);
      chk("b_beats", qb.size(), 32'd5);
      for (int i = 0; i < 5; i++)
         if (i < qb.size()) chk($sformatf("b_beat%0d", i), qb[i], b_exp[i]);

      // ID wrap at 16-bit beats
      chk("c_id_init", 32'(ic.id_o), 32'hFFFF);
      start_hdr(2, 16'd95);
      wait_idle(2, n);
      exp = ref_h; exp[4] = 8'hFF; exp[5] = 8'hFF;
      cmp_hdr("wrap0", qc, exp);
      chk("wrap0_sum", 32'(ocsum(qc)), 32'hFFFF);
      chk("c_id0", 32'(ic.id_o), 32'h0000);
      qc.delete();
      start_hdr(2, 16'd95);
      wait_idle(2, n);
      cmp_hdr("wrap1", qc, ref_h);
      chk("wrap1_sum", 32'(ocsum(qc)), 32'hFFFF);
      chk("c_id1", 32'(ic.id_o), 32'h0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
